lcd_cmd_feeder: RTL and testbench

- Upstream stage of the LCD controller. It buffers host commands in a small FIFO and presents each one on cmd/cmd_valid only while the controller's busy is low.
- For a load command (code 0), it streams the 108-pixel (12x9) image from an external image memory onto datain with exact cycle alignment: pixel k appears k+1 cycles after the issue cycle.
- It sits between the host/testbench command source and the image store on one side, and the LCD controller on the other.

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_cmd_fifo.sv | 62 ++++++
 rtl/lcd_cmd_feeder.sv | 139 +++++++++++++
 tb/tb_lcd_cmd_feeder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command feeder: command codes, image size
// and the feeder state encoding.
package lcd_pkg;

  localparam logic [3:0] LOAD     = 4'd0;
  localparam logic [3:0] ROT_L    = 4'd1;
  localparam logic [3:0] ROT_R    = 4'd2;
  localparam logic [3:0] ZOOM_IN  = 4'd3;
  localparam logic [3:0] ZOOM_FIT = 4'd4;
  localparam logic [3:0] SH_R     = 4'd5;
  localparam logic [3:0] SH_L     = 4'd6;
  localparam logic [3:0] SH_U     = 4'd7;
  localparam logic [3:0] SH_D     = 4'd8;
  localparam logic [3:0] CMD_MAX  = 4'd8;

  localparam int IMG_PIX = 108;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_WAIT_HI = 2'd3
  } feeder_state_e;

  // Codes above CMD_MAX are rejected at the host interface.
  function automatic logic cmd_legal(input logic [3:0] code);
    return (code <= CMD_MAX);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is honoured
// only when a pop happens in the same cycle. Reads as zero when empty.
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_q == CW'(0));
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/lcd_cmd_feeder.sv
// Buffers host commands and issues them to the LCD controller during its
// busy-low window; LOAD commands stream the 108-pixel image with fixed latency.
module lcd_cmd_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int IMG_PIX    = lcd_pkg::IMG_PIX,
  parameter int AW         = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    host_cmd,
  input  logic                          host_valid,
  output logic                          host_ready,
  output logic                          img_rd,
  output logic [AW-1:0]                 img_addr,
  input  logic [7:0]                    img_data,
  input  logic                          busy,
  output logic [3:0]                    cmd,
  output logic                          cmd_valid,
  output logic [7:0]                    datain,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err
);

  import lcd_pkg::*;

  localparam logic [AW-1:0] LAST_PIX = AW'(IMG_PIX - 1);

  feeder_state_e state_q, state_d;
  logic [AW-1:0] pix_q, pix_d;
  logic          err_q, err_d;
  logic          rd_dly_q;

  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic [3:0]    fifo_head_s;
  logic          accept_s;
  logic          fifo_push_s;
  logic          fifo_pop_s;
  logic          issue_s;
  logic          rd_s;
  logic [AW-1:0] addr_s;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .wdata (host_cmd),
    .rdata (fifo_head_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .count (fifo_count)
  );

  assign host_ready  = !fifo_full_s;
  assign accept_s    = host_valid && !fifo_full_s;
  assign fifo_push_s = accept_s && cmd_legal(host_cmd);
  assign err_d       = err_q || (accept_s && !cmd_legal(host_cmd));

  // Next-state and combinational issue/read controls.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    issue_s = 1'b0;
    rd_s    = 1'b0;
    addr_s  = '0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s && !busy) begin
          issue_s = 1'b1;
          if (fifo_head_s == LOAD) begin
            rd_s    = 1'b1;
            addr_s  = '0;
            pix_d   = AW'(1);
            state_d = ST_STREAM;
          end else begin
            state_d = ST_WAIT_HI;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        rd_s   = 1'b1;
        addr_s = pix_q;
        if (pix_q == LAST_PIX) begin
          pix_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          pix_d   = pix_q + AW'(1);
          state_d = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        // Hold off until the controller's registered busy has risen.
        if (busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HI;
        end
      end
      default: begin
        pix_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset suppresses every strobe in the same cycle so an aborted load
  // produces no further reads.
  assign cmd_valid  = issue_s && !reset;
  assign fifo_pop_s = issue_s && !reset;
  assign img_rd     = rd_s && !reset;
  assign img_addr   = reset ? {AW{1'b0}} : addr_s;
  assign cmd        = fifo_head_s;
  assign datain     = (rd_dly_q && !reset) ? img_data : 8'd0;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pix_q    <= '0;
      err_q    <= 1'b0;
      rd_dly_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      err_q    <= err_d;
      rd_dly_q <= img_rd;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_feeder.sv
// Directed bench for lcd_cmd_feeder with a command scoreboard and a
// one-cycle-latency image memory returning addr+1.
module tb_lcd_cmd_feeder;
  import lcd_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int AW         = 7;
  localparam int CW         = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    host_cmd;
  logic          host_valid;
  logic          host_ready;
  logic          img_rd;
  logic [AW-1:0] img_addr;
  logic [7:0]    img_data = 8'd0;
  logic          busy;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [7:0]    datain;
  logic [CW-1:0] fifo_count;
  logic          err;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [3:0] sb [$];

  always #5 clk = ~clk;

  lcd_cmd_feeder #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .IMG_PIX    (108),
    .AW         (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .host_cmd   (host_cmd),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .img_rd     (img_rd),
    .img_addr   (img_addr),
    .img_data   (img_data),
    .busy       (busy),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .datain     (datain),
    .fifo_count (fifo_count),
    .err        (err)
  );

  always @(posedge clk) begin
    if (img_rd) img_data <= {1'b0, img_addr} + 8'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push_cmd(input logic [3:0] code, input logic queued);
    host_valid = 1'b1;
    host_cmd   = code;
    if (queued) sb.push_back(code);
    tick();
    host_valid = 1'b0;
  endtask

  task automatic expect_issue(input string tag);
    logic [3:0] exp;
    @(negedge clk);
    exp = (sb.size() != 0) ? sb.pop_front() : 4'hF;
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    chk({tag, "_cmd"}, 32'(cmd), 32'(exp));
  endtask

  // Called in the drive phase of the issue cycle T0; returns in T0+110.
  task automatic run_load(input string tag);
    int exp_d;
    for (int k = 0; k <= 109; k++) begin
      if (k == 0) expect_issue(tag);
      else @(negedge clk);
      chk({tag, "_rd"}, 32'(img_rd), (k <= 107) ? 32'd1 : 32'd0);
      if (k <= 107) chk({tag, "_addr"}, 32'(img_addr), 32'(k));
      exp_d = (k >= 1 && k <= 108) ? k : 0;
      chk({tag, "_datain"}, 32'(datain), 32'(exp_d));
      tick();
    end
  endtask

  initial begin
    reset      = 1'b1;
    host_cmd   = 4'd0;
    host_valid = 1'b0;
    busy       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(host_ready), 32'd1);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_rd", 32'(img_rd), 32'd0);
    chk("rst_addr", 32'(img_addr), 32'd0);
    chk("rst_datain", 32'(datain), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    tick();

    // Full image load
    push_cmd(LOAD, 1'b1);
    run_load("load1");
    busy = 1'b1;
    tick();

    // Three queued commands, one per busy-low window
    push_cmd(ROT_R, 1'b1);
    push_cmd(SH_U, 1'b1);
    push_cmd(ZOOM_IN, 1'b1);
    @(negedge clk);
    chk("q3_count", 32'(fifo_count), 32'd3);
    chk("q3_valid", 32'(cmd_valid), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      busy = 1'b0;
      expect_issue("seq");
      tick();
      busy = 1'b1;
      @(negedge clk);
      chk("seq_hold", 32'(cmd_valid), 32'd0);
      chk("seq_nord", 32'(img_rd), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("seq_empty", 32'(fifo_count), 32'd0);
    tick();

    // Fill to full, refused push, then pop+push
    push_cmd(ROT_L, 1'b1);
    push_cmd(SH_R, 1'b1);
    push_cmd(SH_L, 1'b1);
    push_cmd(SH_D, 1'b1);
    @(negedge clk);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(host_ready), 32'd0);
    tick();
    push_cmd(ROT_R, 1'b0);
    @(negedge clk);
    chk("full_refuse", 32'(fifo_count), 32'd4);
    tick();
    busy       = 1'b0;
    host_valid = 1'b1;
    host_cmd   = ROT_R;
    expect_issue("pop_full");
    tick();
    host_valid = 1'b0;
    busy       = 1'b1;
    @(negedge clk);
    chk("pop_full_count", 32'(fifo_count), 32'd3);
    tick();
    busy       = 1'b0;
    host_valid = 1'b1;
    host_cmd   = ROT_R;
    sb.push_back(ROT_R);
    expect_issue("pushpop");
    tick();
    host_valid = 1'b0;
    busy       = 1'b1;
    @(negedge clk);
    chk("pushpop_count", 32'(fifo_count), 32'd3);
    chk("pushpop_ready", 32'(host_ready), 32'd1);
    tick();

    // Illegal code sets sticky err without queuing
    push_cmd(4'd12, 1'b0);
    @(negedge clk);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_count", 32'(fifo_count), 32'd3);
    tick();
    push_cmd(ZOOM_FIT, 1'b1);
    @(negedge clk);
    chk("after_ill_count", 32'(fifo_count), 32'd4);
    chk("after_ill_err", 32'(err), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      busy = 1'b0;
      expect_issue("drain");
      tick();
      busy = 1'b1;
      tick();
    end
    @(negedge clk);
    chk("drain_count", 32'(fifo_count), 32'd0);
    chk("drain_err", 32'(err), 32'd1);
    tick();

    // busy held low: no double issue
    push_cmd(ROT_L, 1'b1);
    push_cmd(ROT_R, 1'b1);
    busy = 1'b0;
    expect_issue("dbl_first");
    tick();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("dbl_hold", 32'(cmd_valid), 32'd0);
      tick();
    end
    busy = 1'b1;
    @(negedge clk);
    chk("dbl_hi", 32'(cmd_valid), 32'd0);
    tick();
    busy = 1'b0;
    expect_issue("dbl_second");
    tick();
    busy = 1'b1;
    tick();

    // Reset in the middle of a load, then a fresh load
    busy = 1'b0;
    push_cmd(LOAD, 1'b1);
    expect_issue("abort_issue");
    tick();
    for (int k = 1; k <= 49; k++) begin
      host_valid = (k == 10);
      host_cmd   = ZOOM_IN;
      @(negedge clk);
      chk("abort_addr", 32'(img_addr), 32'(k));
      if (k == 49) chk("abort_count", 32'(fifo_count), 32'd1);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_rd", 32'(img_rd), 32'd0);
    chk("abort_datain", 32'(datain), 32'd0);
    chk("abort_fifo", 32'(fifo_count), 32'd0);
    chk("abort_valid", 32'(cmd_valid), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    tick();
    push_cmd(LOAD, 1'b1);
    run_load("load2");
    busy = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
